sdram_ctrl_init_refresh: RTL

//  Power-up init sequencer and periodic auto-refresh scheduler for the AHB3-Lite multi-port SDRAM ctrl.

---
 rtl/sdram_ctrl_pkg.sv | 53 +++++
 rtl/sdram_ctrl_wait_timer.sv | 27 ++
 rtl/sdram_ctrl_init_refresh.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_ctrl_pkg.sv
// sdram_ctrl_pkg: shared types for the SDRAM controller slice.
//   sdram_cmds_t     : {cke, cs_n, ras_n, cas_n, we_n} command encoding
//   init_ref_state_t : init / refresh sequencer states
//   MRS field constants and the mode-register value builder.
// Optional feature macro: SDRAM_CTRL_SELF_REFRESH_EN (adds self-refresh states).
package sdram_ctrl_pkg;

  typedef enum logic [4:0] {
    CMD_NOP   = 5'b10111,
    CMD_ACT   = 5'b10011,
    CMD_READ  = 5'b10101,
    CMD_WRITE = 5'b10100,
    CMD_PRE   = 5'b10010,
    CMD_REF   = 5'b10001,
    CMD_MRS   = 5'b10000,
    CMD_SELF  = 5'b00001
  } sdram_cmds_t;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_PRE_WAIT,
    ST_INIT_REF,
    ST_INIT_REF_WAIT,
    ST_INIT_MRS,
    ST_INIT_MRS_WAIT,
    ST_READY,
    ST_REF_PRE,
    ST_REF_PRE_WAIT,
    ST_REF,
    ST_REF_WAIT
`ifdef SDRAM_CTRL_SELF_REFRESH_EN
    ,
    ST_SR_PRE,
    ST_SR_PRE_WAIT,
    ST_SR_ENTER,
    ST_SR_ACTIVE,
    ST_SR_EXIT,
    ST_SR_EXIT_WAIT
`endif
  } init_ref_state_t;

  localparam logic        MRS_BT_SEQ   = 1'b0;   // sequential burst type
  localparam logic        MRS_WB_BURST = 1'b0;   // writes use programmed burst length
  localparam logic [13:0] ADDR_PRE_ALL = 14'h0400;

  // A[13:10]=0, A9=write burst, A[8:7]=0, A[6:4]=CL, A3=BT, A[2:0]=BL
  function automatic logic [13:0] mrs_value(input logic [1:0] cl, input logic [1:0] bl);
    return {4'b0000, MRS_WB_BURST, 2'b00, 1'b0, cl, MRS_BT_SEQ, 1'b0, bl};
  endfunction

endpackage

// File: rtl/sdram_ctrl_wait_timer.sv
// sdram_ctrl_wait_timer: loadable down-counter, done while the count is zero.
//   clk_sys  in  clock
//   rst_b    in  async active-low reset
//   load     in  load load_val this cycle
//   load_val in  W-bit start value (cycles - 1 until done)
//   done     out count has reached zero
module sdram_ctrl_wait_timer #(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sdram_ctrl_init_refresh.sv
// sdram_ctrl_init_refresh: power-up init sequencer and auto-refresh scheduler.
// Shares the SDRAM command bus with the main scheduler via cmd_req/cmd_gnt.
// Ports: HCLK, HRESETn; csr_ena/cl/bl/tRP/tRC/tREF config; all_banks_idle;
//   init_done, ref_req, ref_urgent, ref_ack, ref_overflow; cmd_req, cmd_gnt, cmd, cmd_addr.
// Optional macro SDRAM_CTRL_SELF_REFRESH_EN adds sr_req (in) / sr_ack (out).
//
// state            | meaning
// IDLE             | disabled, NOP
// INIT_WAIT        | power-up delay
// INIT_PRE(_WAIT)  | PRE-all, then tRP
// INIT_REF(_WAIT)  | init REF, then tRC, INIT_REF_CNT times
// INIT_MRS(_WAIT)  | mode register set, then TMRD
// READY            | init done, waiting for refresh work
// REF_PRE(_WAIT)   | PRE-all before refresh when banks are open
// REF(_WAIT)       | REF, then tRC, until nothing pending
// SR_*             | self-refresh entry / hold / exit (optional)
module sdram_ctrl_init_refresh
  import sdram_ctrl_pkg::*;
#(
  parameter int INIT_DLY_CNT = 25000,
  parameter int INIT_REF_CNT = 8,
  parameter int MAX_PENDING  = 8,
  parameter int TMRD         = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        csr_ena,
  input  logic [1:0]  csr_cl,
  input  logic [1:0]  csr_bl,
  input  logic [3:0]  csr_tRP,
  input  logic [3:0]  csr_tRC,
  input  logic [15:0] csr_tREF,
  input  logic        all_banks_idle,
  output logic        init_done,
  output logic        ref_req,
  output logic        ref_urgent,
  input  logic        ref_ack,
  output logic        ref_overflow,
`ifdef SDRAM_CTRL_SELF_REFRESH_EN
  input  logic        sr_req,
  output logic        sr_ack,
`endif
  output logic        cmd_req,
  input  logic        cmd_gnt,
  output sdram_cmds_t cmd,
  output logic [13:0] cmd_addr
);

  localparam int          PW        = $clog2(MAX_PENDING + 1);
  localparam logic [15:0] DLY_LD    = 16'(INIT_DLY_CNT - 1);
  localparam logic        TMRD_LONG = (TMRD > 1);
  localparam logic [15:0] TMRD_LD   = (TMRD > 1) ? 16'(TMRD - 2) : 16'd0;

  init_ref_state_t state, nxt;
  logic            tmr_load, tmr_done;
  logic [15:0]     tmr_val;
  logic [7:0]      init_refs;
  logic [15:0]     ref_tmr;
  logic [PW-1:0]   pending, pending_d;
  logic            ref_run, ref_tick, ref_gnt, ovf_set;
  logic            trp_long, trc_long;
  logic [15:0]     trp_ld, trc_ld;

  // A wait of t cycles after the grant means t-1 wait-state cycles, so the
  // timer is loaded with t-2; t<=1 skips the wait state entirely.
  assign trp_long = (csr_tRP > 4'd1);
  assign trc_long = (csr_tRC > 4'd1);
  assign trp_ld   = {12'd0, csr_tRP} - 16'd2;
  assign trc_ld   = {12'd0, csr_tRC} - 16'd2;

  sdram_ctrl_wait_timer #(.W(16)) u_wait (
    .clk_sys  (HCLK),
    .rst_b    (HRESETn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign ref_run    = (state == ST_READY)    || (state == ST_REF_PRE) ||
                      (state == ST_REF_PRE_WAIT) || (state == ST_REF) ||
                      (state == ST_REF_WAIT);
  assign ref_tick   = ref_run && (csr_tREF != 16'd0) && (ref_tmr == 16'd0);
  assign ref_gnt    = (state == ST_REF) && cmd_gnt;
  assign ref_req    = ref_run && (pending != '0);
  assign ref_urgent = (pending == PW'(MAX_PENDING));
  assign init_done  = (state >= ST_READY);
`ifdef SDRAM_CTRL_SELF_REFRESH_EN
  assign sr_ack     = (state == ST_SR_ACTIVE);
`endif

  // A tick and a REF grant in the same cycle cancel out; a tick that finds
  // the counter saturated is lost and flagged.
  always_comb begin
    pending_d = pending;
    ovf_set   = 1'b0;
    if (ref_tick && !ref_gnt) begin
      if (pending != PW'(MAX_PENDING)) pending_d = pending + 1'b1;
      else                             ovf_set   = 1'b1;
    end else if (!ref_tick && ref_gnt && pending != '0) begin
      pending_d = pending - 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= ST_IDLE;
      init_refs    <= '0;
      ref_tmr      <= '0;
      pending      <= '0;
      ref_overflow <= 1'b0;
    end else begin
      state <= nxt;
      if (!csr_ena || state == ST_IDLE)         init_refs <= '0;
      else if (state == ST_INIT_REF && cmd_gnt) init_refs <= init_refs + 8'd1;
      if (ref_run)
        ref_tmr <= (ref_tmr == 16'd0) ? csr_tREF - 16'd1 : ref_tmr - 16'd1;
`ifdef SDRAM_CTRL_SELF_REFRESH_EN
      else if (state >= ST_SR_PRE)
        ref_tmr <= ref_tmr;
`endif
      else
        ref_tmr <= csr_tREF - 16'd1;
      if (!csr_ena) begin
        pending      <= '0;
        ref_overflow <= 1'b0;
`ifdef SDRAM_CTRL_SELF_REFRESH_EN
      end else if (state >= ST_SR_PRE) begin
        pending      <= '0;
`endif
      end else begin
        pending <= pending_d;
        if (ovf_set) ref_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt      = state;
    cmd_req  = 1'b0;
    cmd      = CMD_NOP;
    cmd_addr = '0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: if (csr_ena) begin
        nxt = ST_INIT_WAIT; tmr_load = 1'b1; tmr_val = DLY_LD;
      end
      ST_INIT_WAIT: if (tmr_done) nxt = ST_INIT_PRE;
      ST_INIT_PRE: begin
        cmd_req = 1'b1; cmd = CMD_PRE; cmd_addr = ADDR_PRE_ALL;
        if (cmd_gnt) begin
          nxt = trp_long ? ST_INIT_PRE_WAIT : ST_INIT_REF;
          tmr_load = trp_long; tmr_val = trp_ld;
        end
      end
      ST_INIT_PRE_WAIT: if (tmr_done) nxt = ST_INIT_REF;
      ST_INIT_REF: begin
        cmd_req = 1'b1; cmd = CMD_REF;
        if (cmd_gnt) begin
          tmr_load = trc_long; tmr_val = trc_ld;
          if (trc_long)                                nxt = ST_INIT_REF_WAIT;
          else if (init_refs == 8'(INIT_REF_CNT - 1))  nxt = ST_INIT_MRS;
        end
      end
      ST_INIT_REF_WAIT: if (tmr_done)
        nxt = (init_refs == 8'(INIT_REF_CNT)) ? ST_INIT_MRS : ST_INIT_REF;
      ST_INIT_MRS: begin
        cmd_req = 1'b1; cmd = CMD_MRS; cmd_addr = mrs_value(csr_cl, csr_bl);
        if (cmd_gnt) begin
          nxt = TMRD_LONG ? ST_INIT_MRS_WAIT : ST_READY;
          tmr_load = TMRD_LONG; tmr_val = TMRD_LD;
        end
      end
      ST_INIT_MRS_WAIT: if (tmr_done) nxt = ST_READY;
      ST_READY: begin
`ifdef SDRAM_CTRL_SELF_REFRESH_EN
        if (sr_req) nxt = all_banks_idle ? ST_SR_ENTER : ST_SR_PRE;
        else
`endif
        if (ref_req && ref_ack) nxt = all_banks_idle ? ST_REF : ST_REF_PRE;
      end
      ST_REF_PRE: begin
        cmd_req = 1'b1; cmd = CMD_PRE; cmd_addr = ADDR_PRE_ALL;
        if (cmd_gnt) begin
          nxt = trp_long ? ST_REF_PRE_WAIT : ST_REF;
          tmr_load = trp_long; tmr_val = trp_ld;
        end
      end
      ST_REF_PRE_WAIT: if (tmr_done) nxt = ST_REF;
      ST_REF: begin
        cmd_req = 1'b1; cmd = CMD_REF;
        if (cmd_gnt) begin
          tmr_load = trc_long; tmr_val = trc_ld;
          if (trc_long) nxt = ST_REF_WAIT;
          else          nxt = (pending_d != '0) ? ST_REF : ST_READY;
        end
      end
      ST_REF_WAIT: if (tmr_done) nxt = (pending != '0) ? ST_REF : ST_READY;
`ifdef SDRAM_CTRL_SELF_REFRESH_EN
      ST_SR_PRE: begin
        cmd_req = 1'b1; cmd = CMD_PRE; cmd_addr = ADDR_PRE_ALL;
        if (cmd_gnt) begin
          nxt = trp_long ? ST_SR_PRE_WAIT : ST_SR_ENTER;
          tmr_load = trp_long; tmr_val = trp_ld;
        end
      end
      ST_SR_PRE_WAIT: if (tmr_done) nxt = ST_SR_ENTER;
      ST_SR_ENTER: begin
        cmd_req = 1'b1; cmd = CMD_SELF;
        if (cmd_gnt) nxt = ST_SR_ACTIVE;
      end
      // Keep driving CKE low for the whole self-refresh period.
      ST_SR_ACTIVE: begin
        cmd = CMD_SELF;
        if (!sr_req) nxt = ST_SR_EXIT;
      end
      ST_SR_EXIT: begin
        cmd_req = 1'b1; cmd = CMD_NOP;
        if (cmd_gnt) begin
          nxt = trc_long ? ST_SR_EXIT_WAIT : ST_REF;
          tmr_load = trc_long; tmr_val = trc_ld;
        end
      end
      ST_SR_EXIT_WAIT: if (tmr_done) nxt = ST_REF;
`endif
      default: nxt = ST_IDLE;
    endcase
    if (!csr_ena) nxt = ST_IDLE;
  end

endmodule
